// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// Segment patterns are active-high, bit 0 = a through bit 6 = g.
package hex_display_scanner_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam seg_t SEG_BLANK = 7'b000_0000;
  localparam seg_t SEG_DASH  = seg_t'(1 << SEG_G);

  // Maps an active-high pattern to the board's pin polarity.
  function automatic seg_t seg_polarity(input seg_t seg, input bit active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/hex_display_scanner_decoder.sv
// Team hex-to-7-segment decoder: one nibble in, active-high segment pattern out.
module binary_to_hex_7segDecoder
  import hex_display_scanner_pkg::*;
(
  input  logic [3:0] bin_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (bin_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment driver: one digit per refresh slot, a blank gap
// at every digit change, optional leading-zero suppression.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(REFRESH_DIV - 1);
  localparam logic [TICK_W-1:0]     TICK_BLNK = TICK_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW_AN}};
  localparam seg_t                  SEG_OFF   = seg_polarity(SEG_BLANK, ACTIVE_LOW_SEG);

  logic [4*NUM_DIGITS-1:0] hold_q, hold_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic                    lit_q, lit_d;

  logic                    last_tick, last_idx, blank_phase, suppress;
  logic [NUM_DIGITS-1:0]   upper_zero, an_on;
  logic                    zero_run;
  logic [3:0]              nibble;
  seg_t                    dec_seg;

  assign last_tick   = (tick_q == TICK_LAST);
  assign last_idx    = (idx_q == IDX_LAST);
  assign tick_d      = last_tick ? '0 : tick_q + TICK_W'(1);
  assign idx_d       = last_tick ? (last_idx ? '0 : idx_q + IDX_W'(1)) : idx_q;
  assign blank_phase = (tick_d < TICK_BLNK);
  assign hold_d      = load ? value_in : hold_q;

  // Outputs are built from next-state indices so they line up with the counters.
  assign nibble = hold_q[{idx_d, 2'b00} +: 4];

  binary_to_hex_7segDecoder u_decoder (
    .bin_i (nibble),
    .seg_o (dec_seg)
  );

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the held value are all zero.
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (hold_q[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
  end

  assign suppress = blank_lz && (idx_d != '0) && upper_zero[idx_d];
  assign an_on    = (NUM_DIGITS'(1) << idx_d) ^ AN_OFF;

  // Blank phase reloads the digit; drive phase freezes it so a lit digit never changes.
  always_comb begin
    seg_d        = seg_q;
    dp_d         = dp_q;
    lit_d        = lit_q;
    an_d         = AN_OFF;
    frame_done_d = last_tick && last_idx;
    if (blank_phase) begin
      seg_d = seg_polarity(dec_seg, ACTIVE_LOW_SEG);
      dp_d  = dp_in[idx_d] ^ ACTIVE_LOW_SEG;
      lit_d = !suppress;
    end else if (lit_q) begin
      an_d = an_on;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      tick_q       <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= ACTIVE_LOW_SEG;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
      lit_q        <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      lit_q        <= lit_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: an edge-count based reference model
// predicts every cycle's outputs; a monitor compares them one cycle later.
module tb_hex_display_scanner;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  hex_display_scanner #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (DIV),
    .BLANK_CYCLES   (BLANK),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Active-high hex glyphs, g..a.
  logic [6:0] glyph [16];
  initial begin
    glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
    glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
    glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
    glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
  end

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          started  = 1'b0;
  int          cyc_no   = 0;

  // Reference model: m_k counts edges since reset release.
  int          m_k = 0;
  logic [15:0] m_hold = '0;
  logic [6:0]  sh_seg = 7'h7F;
  logic        sh_dp = 1'b1;
  bit          sh_lit = 1'b0;
  logic [3:0]  cur_dp = '0;
  logic        cur_blz = 1'b0;

  task automatic model_step();
    exp_t       e;
    int         kn, tick, dig;
    logic [3:0] nib;
    if (rst) begin
      m_k    = 0;
      m_hold = '0;
      e      = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    end else begin
      kn   = m_k + 1;
      tick = kn % DIV;
      dig  = (kn / DIV) % N;
      e.fd = ((kn % FRAME) == 0);
      if (tick < BLANK) begin
        nib    = 4'(m_hold >> (4 * dig));
        sh_seg = ~glyph[nib];
        sh_dp  = ~dp_in[dig];
        sh_lit = (dig == 0) || !blank_lz || ((m_hold >> (4 * dig)) != 16'h0);
        e.an   = 4'hF;
      end else begin
        e.an = sh_lit ? ~(4'b0001 << dig) : 4'hF;
      end
      e.seg = sh_seg;
      e.dp  = sh_dp;
      if (load) m_hold = value_in;
      m_k = kn;
    end
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [15:0] v);
    @(negedge clk);
    rst      = r;
    load     = ld;
    value_in = v;
    dp_in    = cur_dp;
    blank_lz = cur_blz;
    model_step();
    started  = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < FRAME && (m_k % FRAME) != phase; i++) cyc(1'b0, 1'b0, 16'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (started) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard cycle %0d: no expected entry queued", cyc_no);
        end else begin
          e = sb_q.pop_front();
          if ({an_out, seg_out, dp_out, frame_done} !== e) begin
            n_fail++;
            $display("FAIL scan cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                     cyc_no, an_out, seg_out, dp_out, frame_done, e.an, e.seg, e.dp, e.fd);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [15:0] v;
    repeat (3) cyc(1'b1, 1'b0, 16'h0);

    cyc(1'b0, 1'b1, 16'h1234);
    idle(70);

    cur_blz = 1'b1;
    cyc(1'b0, 1'b1, 16'h0050);
    idle(70);
    cyc(1'b0, 1'b1, 16'h0000);
    idle(40);

    // Load during digit 0 DRIVE at tick 4.
    cur_blz = 1'b0;
    run_until(3);
    cyc(1'b0, 1'b1, 16'hFFFF);
    idle(40);

    // Decimal point on digit 2, then dropped mid-DRIVE of digit 2.
    cur_dp = 4'b0100;
    idle(40);
    run_until(2 * DIV + 3);
    cur_dp = 4'b0000;
    idle(40);

    // Reset while at digit 2, tick 5.
    run_until(2 * DIV + 5);
    cyc(1'b1, 1'b0, 16'h0);
    idle(40);

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 9) == 0) cur_dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) cur_blz = ~cur_blz;
      v = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0), v);
    end

    @(posedge clk);
    #2;
    started = 1'b0;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
